// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory.
// Each access takes two cycles: one cycle to arbitrate (IDLE) and one cycle to access the memory (ACCESS).
module mem_port_arbiter #(
    parameter int WORD  = 16,
    parameter int AW    = 11,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            a_req,
    input  logic            a_we,
    input  logic [AW-1:0]   a_addr,
    input  logic [WORD-1:0] a_wdata,
    output logic            a_gnt,
    output logic            a_rvalid,
    output logic [WORD-1:0] a_rdata,
    input  logic            b_req,
    input  logic            b_we,
    input  logic [AW-1:0]   b_addr,
    input  logic [WORD-1:0] b_wdata,
    output logic            b_gnt,
    output logic            b_rvalid,
    output logic [WORD-1:0] b_rdata,
    output logic            mem_we,
    output logic            mem_re,
    output logic [AW-1:0]   mem_addr,
    output logic [WORD-1:0] mem_wdata,
    input  logic [WORD-1:0] mem_rdata,
    output logic            err
);

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    // Port encoding: 0 = A, 1 = B.
    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    logic            rr_last_q, rr_last_d;
    logic            cmd_we_q, cmd_we_d;
    logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
    logic [WORD-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [WORD-1:0] a_rdata_q, a_rdata_d;
    logic [WORD-1:0] b_rdata_q, b_rdata_d;
    logic            a_rvalid_q, a_rvalid_d;
    logic            b_rvalid_q, b_rvalid_d;
    logic            err_q, err_d;
    logic            winner;
    logic            in_range;
    logic            in_access;

    assign in_range  = ({1'b0, cmd_addr_q} < DEPTH_W);
    assign in_access = (state_q == ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            rr_last_q   <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_last_q   <= rr_last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_last_d   = rr_last_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_rvalid_d  = 1'b0;
        b_rvalid_d  = 1'b0;
        err_d       = 1'b0;
        winner      = 1'b0;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // On a tie the port that was not granted last time wins.
                    if (a_req && !b_req)      winner = 1'b0;
                    else if (b_req && !a_req) winner = 1'b1;
                    else                      winner = ~rr_last_q;
                    sel_d       = winner;
                    rr_last_d   = winner;
                    cmd_we_d    = winner ? b_we    : a_we;
                    cmd_addr_d  = winner ? b_addr  : a_addr;
                    cmd_wdata_d = winner ? b_wdata : a_wdata;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (!cmd_we_q) begin
                    if (sel_q) begin
                        b_rvalid_d = 1'b1;
                        b_rdata_d  = in_range ? mem_rdata : '0;
                    end else begin
                        a_rvalid_d = 1'b1;
                        a_rdata_d  = in_range ? mem_rdata : '0;
                    end
                end
                err_d   = ~in_range;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign a_gnt     = in_access & ~sel_q;
    assign b_gnt     = in_access &  sel_q;
    assign mem_re    = in_access & ~cmd_we_q & in_range;
    assign mem_we    = in_access &  cmd_we_q & in_range;
    assign mem_addr  = in_access ? cmd_addr_q  : '0;
    assign mem_wdata = in_access ? cmd_wdata_q : '0;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural 1024-word memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [10:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        mem_we, mem_re, err;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [15:0] mem [0:1023];

    int checks = 0;
    int passes = 0;

    mem_port_arbiter #(.WORD(16), .AW(11), .DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the rising edge.
    assign mem_rdata = (mem_re && mem_addr < 11'd1024) ? mem[mem_addr[9:0]] : 16'h0000;
    always @(posedge clk) if (mem_we && mem_addr < 11'd1024) mem[mem_addr[9:0]] <= mem_wdata;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'd0; a_wdata = 16'h0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 11'd0; b_wdata = 16'h0;
        tick; tick;
        checks++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid, err} !== 5'b0) $display("[TB] FAIL rst_flags: got %b expected 00000", {a_gnt, b_gnt, a_rvalid, b_rvalid, err}); else passes++;
        checks++; if ({mem_we, mem_re} !== 2'b00) $display("[TB] FAIL rst_strobes: got %b expected 00", {mem_we, mem_re}); else passes++;
        checks++; if ({mem_addr, mem_wdata} !== 27'h0) $display("[TB] FAIL rst_mem_bus: got %h expected 0", {mem_addr, mem_wdata}); else passes++;
        checks++; if ({a_rdata, b_rdata} !== 32'h0) $display("[TB] FAIL rst_rdata: got %h expected 0", {a_rdata, b_rdata}); else passes++;
        rst_n = 1'b1;
        tick;
        checks++; if ({a_gnt, b_gnt} !== 2'b10) $display("[TB] FAIL rst_first_gnt: got %b expected 10", {a_gnt, b_gnt}); else passes++;
        a_req = 1'b0; b_req = 1'b0;
        tick; tick;
    endtask

    task automatic test_read;
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'd5;
        tick;
        checks++; if ({a_gnt, b_gnt} !== 2'b10) $display("[TB] FAIL rd_gnt: got %b expected 10", {a_gnt, b_gnt}); else passes++;
        checks++; if ({mem_re, mem_we} !== 2'b10) $display("[TB] FAIL rd_strobes: got %b expected 10", {mem_re, mem_we}); else passes++;
        checks++; if (mem_addr !== 11'd5) $display("[TB] FAIL rd_addr: got %0d expected 5", mem_addr); else passes++;
        a_req = 1'b0;
        tick;
        checks++; if (a_rvalid !== 1'b1) $display("[TB] FAIL rd_rvalid: got %b expected 1", a_rvalid); else passes++;
        checks++; if (a_rdata !== 16'h1234) $display("[TB] FAIL rd_rdata: got %h expected 1234", a_rdata); else passes++;
        checks++; if ({a_gnt, mem_re, err} !== 3'b000) $display("[TB] FAIL rd_idle: got %b expected 000", {a_gnt, mem_re, err}); else passes++;
        tick;
        checks++; if (a_rvalid !== 1'b0) $display("[TB] FAIL rd_rvalid_pulse: got %b expected 0", a_rvalid); else passes++;
    endtask

    task automatic test_write_read;
        b_req = 1'b1; b_we = 1'b1; b_addr = 11'd10; b_wdata = 16'hBEEF;
        tick;
        checks++; if ({a_gnt, b_gnt} !== 2'b01) $display("[TB] FAIL wr_gnt: got %b expected 01", {a_gnt, b_gnt}); else passes++;
        checks++; if ({mem_we, mem_re} !== 2'b10) $display("[TB] FAIL wr_strobes: got %b expected 10", {mem_we, mem_re}); else passes++;
        checks++; if ({mem_addr, mem_wdata} !== {11'd10, 16'hBEEF}) $display("[TB] FAIL wr_bus: got %0d/%h expected 10/beef", mem_addr, mem_wdata); else passes++;
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'd10;
        tick;
        checks++; if ({b_rvalid, err, a_gnt} !== 3'b000) $display("[TB] FAIL wr_no_rvalid: got %b expected 000", {b_rvalid, err, a_gnt}); else passes++;
        tick;
        checks++; if ({a_gnt, mem_re} !== 2'b11) $display("[TB] FAIL wr_rd_gnt: got %b expected 11", {a_gnt, mem_re}); else passes++;
        a_req = 1'b0;
        tick;
        checks++; if ({a_rvalid, a_rdata} !== {1'b1, 16'hBEEF}) $display("[TB] FAIL wr_rd_data: got %b/%h expected 1/beef", a_rvalid, a_rdata); else passes++;
        tick;
    endtask

    task automatic test_out_of_range;
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'd1500;
        tick;
        checks++; if ({a_gnt, mem_we, mem_re} !== 3'b100) $display("[TB] FAIL oor_a_strobes: got %b expected 100", {a_gnt, mem_we, mem_re}); else passes++;
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 11'd1024; b_wdata = 16'h5555;
        tick;
        checks++; if ({a_rvalid, a_rdata} !== {1'b1, 16'h0000}) $display("[TB] FAIL oor_a_rdata: got %b/%h expected 1/0000", a_rvalid, a_rdata); else passes++;
        checks++; if (err !== 1'b1) $display("[TB] FAIL oor_a_err: got %b expected 1", err); else passes++;
        tick;
        checks++; if ({b_gnt, mem_we, mem_re} !== 3'b100) $display("[TB] FAIL oor_b_strobes: got %b expected 100", {b_gnt, mem_we, mem_re}); else passes++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL oor_err_pulse: got %b expected 0", err); else passes++;
        b_req = 1'b0;
        tick;
        checks++; if ({err, b_rvalid} !== 2'b10) $display("[TB] FAIL oor_b_err: got %b expected 10", {err, b_rvalid}); else passes++;
        checks++; if (mem[0] !== 16'h0000) $display("[TB] FAIL oor_no_wrap: got %h expected 0000", mem[0]); else passes++;
        tick;
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_gnt;
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'd5;
        b_req = 1'b1; b_we = 1'b0; b_addr = 11'd10;
        for (int k = 0; k < 16; k++) begin
            tick;
            if (k % 2 == 1)            exp_gnt = 2'b00;
            else if ((k / 2) % 2 == 0) exp_gnt = 2'b10;
            else                       exp_gnt = 2'b01;
            checks++; if ({a_gnt, b_gnt} !== exp_gnt) $display("[TB] FAIL rr_gnt_%0d: got %b expected %b", k, {a_gnt, b_gnt}, exp_gnt); else passes++;
        end
        a_req = 1'b0; b_req = 1'b0;
        checks++; if ({b_rvalid, b_rdata} !== {1'b1, 16'hBEEF}) $display("[TB] FAIL rr_last_b_data: got %b/%h expected 1/beef", b_rvalid, b_rdata); else passes++;
        tick; tick;
    endtask

    task automatic test_reset_mid_access;
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'd5;
        tick;
        checks++; if (a_gnt !== 1'b1) $display("[TB] FAIL mid_gnt_before: got %b expected 1", a_gnt); else passes++;
        a_req = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if ({a_gnt, b_gnt, mem_re, mem_we} !== 4'b0000) $display("[TB] FAIL mid_drop: got %b expected 0000", {a_gnt, b_gnt, mem_re, mem_we}); else passes++;
        checks++; if (mem_addr !== 11'd0) $display("[TB] FAIL mid_addr: got %0d expected 0", mem_addr); else passes++;
        tick;
        checks++; if ({a_rvalid, err} !== 2'b00) $display("[TB] FAIL mid_no_rvalid: got %b expected 00", {a_rvalid, err}); else passes++;
        rst_n = 1'b1;
        tick;
        checks++; if ({a_rvalid, a_gnt, err} !== 3'b000) $display("[TB] FAIL mid_after_release: got %b expected 000", {a_rvalid, a_gnt, err}); else passes++;
        b_req = 1'b1; b_we = 1'b0; b_addr = 11'd10;
        tick;
        checks++; if ({a_gnt, b_gnt} !== 2'b01) $display("[TB] FAIL mid_idle_gnt: got %b expected 01", {a_gnt, b_gnt}); else passes++;
        b_req = 1'b0;
        tick;
        checks++; if ({b_rvalid, b_rdata} !== {1'b1, 16'hBEEF}) $display("[TB] FAIL mid_b_data: got %b/%h expected 1/beef", b_rvalid, b_rdata); else passes++;
        tick;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[5] = 16'h1234;
        test_reset;
        test_read;
        test_write_read;
        test_out_of_range;
        test_back_to_back;
        test_reset_mid_access;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
